// File: rtl/remap_table_loader.sv
// rtl/remap_table_loader.sv - command-driven loader and verifier for the remap register file
//
// Converts host commands into write-port traffic for the remap register file
// and runs read-back verify sweeps through its combinational debug port.
//   clk, reset_n              : clock, asynchronous active-low reset
//   cmd_valid/ready/op/addr/data : host command handshake (accepted only in IDLE)
//   rf_we, rf_addr, rf_data   : register file write port (rf_addr also drives the debug read index)
//   rf_rdata                  : register file debug read data, combinational in rf_addr
//   busy, done                : state not IDLE; one-cycle completion pulse
//   err_count, first_err_addr, err_flag : results of the most recent verify
module remap_table_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE1,
        S_FILL,
        S_VERIFY,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic                pat_const_q;   // 1: constant pattern, 0: identity pattern
    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_addr_q;
    logic [DATA_W-1:0]   rf_data_q;
    logic                done_q;
    logic [7:0]          err_count_q;
    logic [ADDR_W-1:0]   first_err_addr_q;
    logic                err_flag_q;

    logic [ADDR_W-1:0]   cnt_nxt;
    logic [DATA_W-1:0]   exp_val;
    logic                mismatch;

    assign cnt_nxt  = cnt_q + ADDR_ONE;
    assign exp_val  = pat_const_q ? data_q : DATA_W'(cnt_q);
    // rf_addr equals cnt_q throughout VERIFY, so rf_rdata belongs to cnt_q.
    assign mismatch = (rf_rdata != exp_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            data_q           <= '0;
            pat_const_q      <= 1'b0;
            rf_we_q          <= 1'b0;
            rf_addr_q        <= '0;
            rf_data_q        <= '0;
            done_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            err_flag_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        data_q      <= cmd_data;
                        pat_const_q <= (cmd_op == 2'b10) || ((cmd_op == 2'b11) && cmd_addr[0]);
                        cnt_q       <= '0;
                        // Output registers are loaded here so the first write/read
                        // address is valid in the very first cycle after accept.
                        case (cmd_op)
                            2'b00: begin
                                state_q   <= S_WRITE1;
                                rf_we_q   <= 1'b1;
                                rf_addr_q <= cmd_addr;
                                rf_data_q <= cmd_data;
                            end
                            2'b01, 2'b10: begin
                                state_q   <= S_FILL;
                                rf_we_q   <= 1'b1;
                                rf_addr_q <= '0;
                                rf_data_q <= (cmd_op == 2'b10) ? cmd_data : '0;
                            end
                            default: begin
                                state_q          <= S_VERIFY;
                                rf_we_q          <= 1'b0;
                                rf_addr_q        <= '0;
                                err_count_q      <= '0;
                                first_err_addr_q <= '0;
                                err_flag_q       <= 1'b0;
                            end
                        endcase
                    end
                end
                S_WRITE1: begin
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_FILL: begin
                    if (cnt_q == LAST_ADDR) begin
                        rf_we_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q     <= cnt_nxt;
                        rf_addr_q <= cnt_nxt;
                        rf_data_q <= pat_const_q ? data_q : DATA_W'(cnt_nxt);
                    end
                end
                S_VERIFY: begin
                    if (mismatch) begin
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                        if (!err_flag_q) begin
                            first_err_addr_q <= cnt_q;
                            err_flag_q       <= 1'b1;
                        end
                    end
                    if (cnt_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q     <= cnt_nxt;
                        rf_addr_q <= cnt_nxt;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign rf_we          = rf_we_q;
    assign rf_addr        = rf_addr_q;
    assign rf_data        = rf_data_q;
    assign done           = done_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign err_flag       = err_flag_q;

endmodule

// File: tb/tb_remap_table_loader.sv
// tb/tb_remap_table_loader.sv - directed self-checking bench for remap_table_loader
module tb_remap_table_loader;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_addr;
    logic [6:0] cmd_data;
    logic       rf_we;
    logic [6:0] rf_addr;
    logic [6:0] rf_data;
    logic [6:0] rf_rdata;
    logic       busy;
    logic       done;
    logic [7:0] err_count;
    logic [6:0] first_err_addr;
    logic       err_flag;

    int checks;
    int passed;

    // Register file model: synchronous write, combinational debug read.
    logic [6:0] mem [128];
    assign rf_rdata = mem[rf_addr];
    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_data;
    end

    remap_table_loader #(.ADDR_W(7), .DATA_W(7), .DEPTH(128)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .rf_we          (rf_we),
        .rf_addr        (rf_addr),
        .rf_data        (rf_data),
        .rf_rdata       (rf_rdata),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .err_flag       (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one command and follows it to its done pulse. Returns number of
    // rf_we cycles, busy cycles, and protocol/sequence violations seen.
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] a, input logic [6:0] d,
                           output int nwe, output int nbusy, output int nbad);
        int  idx;
        bit  got_done;
        nwe = 0; nbusy = 0; nbad = 0; idx = 0; got_done = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy) nbusy++;
            if (cmd_ready === busy) nbad++;
            if (rf_we) begin
                nwe++;
                if (op == 2'b00) begin
                    if (rf_addr !== a || rf_data !== d) nbad++;
                end else if (op == 2'b11) begin
                    nbad++;
                end else begin
                    if (rf_addr !== 7'(idx)) nbad++;
                    if (rf_data !== ((op == 2'b01) ? 7'(idx) : d)) nbad++;
                end
                idx++;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got_done) nbad += 1000;
        @(negedge clk);
    endtask

    int nwe, nbusy, nbad;
    int accepts, acc_cyc, done_cyc, w3;

    initial begin
        checks = 0; passed = 0;
        for (int i = 0; i < 128; i++) mem[i] = 7'h00;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_addr", 32'(rf_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_err_count", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write
        run_cmd(2'b00, 7'h15, 7'h2A, nwe, nbusy, nbad);
        chk("wr1_we_cycles", 32'(nwe), 32'd1);
        chk("wr1_busy_cycles", 32'(nbusy), 32'd2);
        chk("wr1_seq", 32'(nbad), 32'd0);
        chk("wr1_table", 32'(mem[7'h15]), 32'h2A);
        chk("wr1_idle_ready", 32'(cmd_ready), 32'd1);
        chk("wr1_idle_done", 32'(done), 32'd0);

        // Fill identity then verify identity
        run_cmd(2'b01, 7'h00, 7'h00, nwe, nbusy, nbad);
        chk("fid_we_cycles", 32'(nwe), 32'd128);
        chk("fid_busy_cycles", 32'(nbusy), 32'd129);
        chk("fid_seq", 32'(nbad), 32'd0);
        chk("fid_table127", 32'(mem[127]), 32'd127);
        run_cmd(2'b11, 7'h00, 7'h00, nwe, nbusy, nbad);
        chk("vid_busy_cycles", 32'(nbusy), 32'd129);
        chk("vid_seq", 32'(nbad), 32'd0);
        chk("vid_err_count", 32'(err_count), 32'd0);
        chk("vid_err_flag", 32'(err_flag), 32'd0);
        chk("vid_first_err", 32'(first_err_addr), 32'd0);

        // Fill constant 0x55, corrupt address 9, verify constant
        run_cmd(2'b10, 7'h00, 7'h55, nwe, nbusy, nbad);
        chk("fc55_seq", 32'(nbad + nwe), 32'd128);
        run_cmd(2'b00, 7'd9, 7'h00, nwe, nbusy, nbad);
        chk("wr9_seq", 32'(nbad), 32'd0);
        run_cmd(2'b11, 7'h01, 7'h55, nwe, nbusy, nbad);
        chk("vc55_err_count", 32'(err_count), 32'd1);
        chk("vc55_first_err", 32'(first_err_addr), 32'd9);
        chk("vc55_err_flag", 32'(err_flag), 32'd1);

        // Fill 0x00, verify identity: only address 0 matches
        run_cmd(2'b10, 7'h00, 7'h00, nwe, nbusy, nbad);
        run_cmd(2'b11, 7'h00, 7'h00, nwe, nbusy, nbad);
        chk("v0_err_count", 32'(err_count), 32'd127);
        chk("v0_first_err", 32'(first_err_addr), 32'd1);
        chk("v0_err_flag", 32'(err_flag), 32'd1);

        // Fill 0x01 leaves status alone; verify identity: only address 1 matches
        run_cmd(2'b10, 7'h00, 7'h01, nwe, nbusy, nbad);
        chk("f1_status_kept_count", 32'(err_count), 32'd127);
        chk("f1_status_kept_first", 32'(first_err_addr), 32'd1);
        run_cmd(2'b11, 7'h00, 7'h00, nwe, nbusy, nbad);
        chk("v1_err_count", 32'(err_count), 32'd127);
        chk("v1_first_err", 32'(first_err_addr), 32'd0);

        // Handshake: new command held valid while a fill is busy
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 7'h00; cmd_data = 7'h11;
        @(negedge clk);
        cmd_op = 2'b00; cmd_addr = 7'd3; cmd_data = 7'd7;
        accepts = 0; acc_cyc = -1; done_cyc = -1; w3 = 0;
        for (int i = 0; i < 160; i++) begin
            if (cmd_valid && cmd_ready) begin
                accepts++;
                acc_cyc = i;
            end
            if (done && done_cyc < 0) done_cyc = i;
            if (rf_we && rf_addr == 7'd3 && rf_data == 7'd7) w3++;
            @(negedge clk);
            if (accepts > 0) cmd_valid = 1'b0;
        end
        chk("hs_accepts", 32'(accepts), 32'd1);
        chk("hs_done_cycle", 32'(done_cyc), 32'd128);
        chk("hs_accept_cycle", 32'(acc_cyc), 32'd129);
        chk("hs_held_write", 32'(w3), 32'd1);
        chk("hs_table3", 32'(mem[3]), 32'd7);

        // Reset mid fill at address 40
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = '0; cmd_data = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rf_addr == 7'd40 && rf_we) break;
            @(negedge clk);
        end
        chk("mid_reached_40", 32'(rf_addr), 32'd40);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rf_we_async", 32'(rf_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_no_write_40", 32'(mem[40]), 32'h11);
        chk("mid_kept_39", 32'(mem[39]), 32'd39);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_after_rf_addr", 32'(rf_addr), 32'd0);
        chk("mid_after_we", 32'(rf_we), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
